debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
- Host-side controller for the `mips` pipeline, bridging a byte-stream UART (rx/tx byte ports) to the CPU.
- Writes programs into instruction memory (the writer side of the IF fetch path).
- Drives the pipeline's `i_stall` for run/step control.
- Reads back PC and register file for dumps.
- Sits in the FPGA top between the UART and `mips`.

Parameters:
- SIZE, 32, data/instruction word width.
- IMEM_ADDR_W, 8, instruction memory word-address width (PC counts words, +1 per instruction).
- NUM_REGS, 32, registers dumped after the PC.
- TIMEOUT_CYCLES, 1000000, load idle timeout (used only with DEBUG_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle pulse; `i_rx_data` is valid.
- o_tx_data  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle pulse; start transmit of `o_tx_data`.
- i_tx_busy  in  1  transmitter busy.
- o_stall  out  1  to `mips.i_stall`; 1 = pipeline frozen.
- o_imem_we  out  1  instruction memory write enable.
- o_imem_addr  out  IMEM_ADDR_W  instruction memory word address.
- o_imem_data  out  SIZE  instruction word to write.
- i_pc  in  SIZE  current PC.
- i_halt  in  1  halt instruction retired in WB.
- o_dbg_reg_addr  out  5  register file debug read address.
- i_dbg_reg_data  in  SIZE  register file debug read data (combinational).

Behaviour:
- Reset (`rst`=0 at a clk edge):
  - state=IDLE, o_stall=1.
  - o_tx_start=0, o_tx_data=0, o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_dbg_reg_addr=0.
  - All counters cleared.
  - Reset mid-operation aborts immediately; no partial byte or word is emitted.
- Commands (IDLE only; any other byte ignored):
  - 'L' 0x4C → LOAD_LEN.
  - 'C' 0x43 → RUN.
  - 'S' 0x53 → STEP.
  - 'D' 0x44 → DUMP.
- LOAD_LEN:
  - Next rx byte N gives the word count; N=0 means 256.
  - Clears word address to 0 → LOAD_DATA.
- LOAD_DATA:
  - Assembles 4 bytes MSB-first into a shift register.
  - On the 4th byte, o_imem_we=1 for exactly one cycle, with o_imem_addr = word index and o_imem_data = assembled word.
  - The word index then increments.
  - After word N is written → ACK: send 0x06, then IDLE.
  - o_stall stays 1 throughout.
- RUN:
  - o_stall=0 until a cycle with i_halt=1.
  - o_stall returns to 1 on the next edge → DUMP.
  - If i_halt is already 1 on entry, at most one unstalled cycle occurs.
- STEP:
  - o_stall=0 for exactly one clk cycle, then 1 → DUMP.
- DUMP:
  - Transmits 4+4·NUM_REGS bytes (132 default): PC MSB-first, then registers 0..NUM_REGS-1 MSB-first.
  - o_dbg_reg_addr holds the current register index; data is sampled when the register's first byte is issued.
  - Then → IDLE.
- TX handshake:
  - o_tx_start pulses for one cycle only when i_tx_busy=0.
  - o_tx_data is held stable until the next pulse.
  - After a pulse, the block waits one cycle (TX_WAIT), then waits for i_tx_busy=0 before the next byte.
  - Never two pulses on consecutive cycles.
- Rx handling:
  - Rx bytes arriving in RUN/STEP/DUMP/ACK are dropped; no buffering.
  - i_rx_valid is honoured only on single-cycle pulses; the byte is consumed on the pulse cycle.
- Widths:
  - Word index is IMEM_ADDR_W bits; it wraps to 0 past 2^IMEM_ADDR_W−1 (silently overwrites).
  - Byte counter is 2 bits; register index counter is 6 bits.

Optional Feature:
- DEBUG_TIMEOUT_EN.
- Defined:
  - In LOAD_LEN/LOAD_DATA, a cycle counter resets on every i_rx_valid.
  - On reaching TIMEOUT_CYCLES with no byte, the load aborts and NAK 0x15 is sent, then IDLE.
  - Words already written remain in memory.
- Undefined:
  - No counter; the load waits indefinitely.

Test Plan:
- Load: rx 0x4C, 0x02, 0x20,0x01,0x00,0x05, 0x00,0x00,0x00,0x3F → two single-cycle o_imem_we pulses: addr 0 / 0x20010005, then addr 1 / 0x0000003F; tx 0x06; o_stall=1 throughout.
- Step: with i_pc=0x00000004 and regs[i]=i, rx 0x53 → o_stall low exactly 1 cycle; tx 132 bytes starting 00 00 00 04 00 00 00 00 00 00 00 01 …, ending 00 00 00 1F.
- Run: rx 0x43, i_halt raised 10 cycles later → o_stall=0 for 10 cycles then 1; dump follows.
- TX backpressure: hold i_tx_busy=1 for 50 cycles after each start pulse → no o_tx_start while busy; byte order intact; no consecutive-cycle pulses.
- Reset mid-load: assert rst=0 after 2 of 4 data bytes, release, then rx 0x44 → IDLE after reset, no o_imem_we, dump transmits normally.
- With DEBUG_TIMEOUT_EN and TIMEOUT_CYCLES=100: rx 0x4C, 0x01, 0xAA, then silence → tx 0x15 at cycle ~100 after 0xAA; no o_imem_we; block accepts 0x44 afterwards.

Source files
------------

// File: rtl/debug_unit.sv
// debug_unit: byte-stream host controller for the mips core (program load, run/step, PC+regfile dump).
// Define DEBUG_TIMEOUT_EN to abort an idle load after TIMEOUT_CYCLES and answer with NAK.
module debug_unit #(
  parameter int unsigned SIZE           = 32,
  parameter int unsigned IMEM_ADDR_W    = 8,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy,
  output logic                   o_stall,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]        o_imem_data,
  input  logic [SIZE-1:0]        i_pc,
  input  logic                   i_halt,
  output logic [4:0]             o_dbg_reg_addr,
  input  logic [SIZE-1:0]        i_dbg_reg_data
);

  localparam logic [7:0] CmdLoad = 8'h4C;
  localparam logic [7:0] CmdRun  = 8'h43;
  localparam logic [7:0] CmdStep = 8'h53;
  localparam logic [7:0] CmdDump = 8'h44;
  localparam logic [7:0] ByteAck = 8'h06;
  localparam logic [5:0] LastReg = 6'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadLen,
    StLoadData,
    StRun,
    StStep,
    StDump,
    StAck
  } state_e;

  state_e                 state_q, state_d;
  logic                   stall_q, stall_d;
  logic                   tx_start_q, tx_start_d;
  logic                   tx_wait_q, tx_wait_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [SIZE-1:0]        imem_data_q, imem_data_d;
  logic [IMEM_ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [8:0]             words_left_q, words_left_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [5:0]             reg_idx_q, reg_idx_d;
  logic                   dump_pc_q, dump_pc_d;
  logic [SIZE-1:0]        shift_q, shift_d;
  logic [7:0]             ack_byte_q, ack_byte_d;
  logic                   rx_valid_q, rx_valid_d;

  logic                   rx_evt;
  logic                   tx_ready;
  logic [SIZE-1:0]        dump_word;

`ifdef DEBUG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Only the first cycle of a valid pulse consumes a byte.
  assign rx_evt    = i_rx_valid && !rx_valid_q;
  // One dead cycle after each start pulse gives the transmitter time to raise busy.
  assign tx_ready  = !tx_start_q && !tx_wait_q && !i_tx_busy;
  assign dump_word = dump_pc_q ? i_pc : i_dbg_reg_data;

  always_comb begin
    state_d      = state_q;
    stall_d      = stall_q;
    tx_start_d   = 1'b0;
    tx_wait_d    = tx_start_q;
    tx_data_d    = tx_data_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    word_idx_d   = word_idx_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    reg_idx_d    = reg_idx_q;
    dump_pc_d    = dump_pc_q;
    shift_d      = shift_q;
    ack_byte_d   = ack_byte_q;
    rx_valid_d   = i_rx_valid;
`ifdef DEBUG_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    case (state_q)
      StIdle: begin
        if (rx_evt) begin
          case (i_rx_data)
            CmdLoad: state_d = StLoadLen;
            CmdRun: begin
              stall_d = 1'b0;
              state_d = StRun;
            end
            CmdStep: begin
              stall_d = 1'b0;
              state_d = StStep;
            end
            CmdDump: begin
              dump_pc_d  = 1'b1;
              byte_cnt_d = 2'd0;
              reg_idx_d  = 6'd0;
              state_d    = StDump;
            end
            default: ;
          endcase
        end
      end

      StLoadLen: begin
        if (rx_evt) begin
          words_left_d = (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
          word_idx_d   = '0;
          byte_cnt_d   = 2'd0;
          state_d      = StLoadData;
        end
      end

      StLoadData: begin
        if (rx_evt) begin
          shift_d    = {shift_q[SIZE-9:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_data_d  = {shift_q[SIZE-9:0], i_rx_data};
            word_idx_d   = word_idx_q + 1'b1;
            words_left_d = words_left_q - 9'd1;
            if (words_left_q == 9'd1) begin
              ack_byte_d = ByteAck;
              state_d    = StAck;
            end
          end
        end
      end

      StRun: begin
        if (i_halt) begin
          stall_d    = 1'b1;
          dump_pc_d  = 1'b1;
          byte_cnt_d = 2'd0;
          reg_idx_d  = 6'd0;
          state_d    = StDump;
        end
      end

      StStep: begin
        stall_d    = 1'b1;
        dump_pc_d  = 1'b1;
        byte_cnt_d = 2'd0;
        reg_idx_d  = 6'd0;
        state_d    = StDump;
      end

      StDump: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // A word is captured when its first byte goes out; later bytes come from the shifter.
          if (byte_cnt_q == 2'd0) begin
            tx_data_d = dump_word[SIZE-1 -: 8];
            shift_d   = dump_word << 8;
          end else begin
            tx_data_d = shift_q[SIZE-1 -: 8];
            shift_d   = shift_q << 8;
          end
          if (byte_cnt_q == 2'd3) begin
            if (dump_pc_q) begin
              dump_pc_d = 1'b0;
            end else if (reg_idx_q == LastReg) begin
              reg_idx_d = 6'd0;
              state_d   = StIdle;
            end else begin
              reg_idx_d = reg_idx_q + 6'd1;
            end
          end
        end
      end

      StAck: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = ack_byte_q;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

`ifdef DEBUG_TIMEOUT_EN
    if (state_q == StLoadLen || state_q == StLoadData) begin
      if (i_rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d      = '0;
        ack_byte_d = 8'h15;
        state_d    = StAck;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end else begin
      tmo_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      stall_q      <= 1'b1;
      tx_start_q   <= 1'b0;
      tx_wait_q    <= 1'b0;
      tx_data_q    <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      word_idx_q   <= '0;
      words_left_q <= 9'd0;
      byte_cnt_q   <= 2'd0;
      reg_idx_q    <= 6'd0;
      dump_pc_q    <= 1'b0;
      shift_q      <= '0;
      ack_byte_q   <= 8'd0;
      rx_valid_q   <= 1'b0;
`ifdef DEBUG_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      tx_start_q   <= tx_start_d;
      tx_wait_q    <= tx_wait_d;
      tx_data_q    <= tx_data_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      word_idx_q   <= word_idx_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      reg_idx_q    <= reg_idx_d;
      dump_pc_q    <= dump_pc_d;
      shift_q      <= shift_d;
      ack_byte_q   <= ack_byte_d;
      rx_valid_q   <= rx_valid_d;
`ifdef DEBUG_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign o_tx_data      = tx_data_q;
  assign o_tx_start     = tx_start_q;
  assign o_stall        = stall_q;
  assign o_imem_we      = imem_we_q;
  assign o_imem_addr    = imem_addr_q;
  assign o_imem_data    = imem_data_q;
  assign o_dbg_reg_addr = reg_idx_q[4:0];

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: tx bytes and imem writes are queued as expected and popped on output.
module tb_debug_unit;
  localparam int unsigned AW   = 8;
  localparam int unsigned NREG = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        stall;
  logic        imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic        halt = 1'b0;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] regs [NREG];

  logic [7:0]      tx_exp [$];
  logic [AW+31:0]  we_exp [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int busy_len = 2;
  int busy_left = 0;
  int stall_low_cnt = 0;
  int tx_count = 0;
  int we_count = 0;
  int last_tx_cycle = 0;
  int halt_after = 0;
  bit halt_arm = 1'b0;
  bit prev_start = 1'b0;
  bit prev_we = 1'b0;

  always #5 clk = ~clk;

  assign dbg_data = regs[dbg_addr];

  debug_unit #(
    .SIZE(32),
    .IMEM_ADDR_W(AW),
    .NUM_REGS(NREG),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .i_tx_busy(tx_busy),
    .o_stall(stall),
    .o_imem_we(imem_we),
    .o_imem_addr(imem_addr),
    .o_imem_data(imem_data),
    .i_pc(pc),
    .i_halt(halt),
    .o_dbg_reg_addr(dbg_addr),
    .i_dbg_reg_data(dbg_data)
  );

  // Monitor, transmitter busy model and halt generator, all sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0]     exp_b;
    logic [AW+31:0] exp_w;
    cycle = cycle + 1;
    if (rst === 1'b1) begin
      if (stall === 1'b0) stall_low_cnt = stall_low_cnt + 1;
      if (tx_start === 1'b1) begin
        tx_count = tx_count + 1;
        last_tx_cycle = cycle;
        n_checks = n_checks + 1;
        if (tx_exp.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL tx_unexpected: got byte %h, expected no transmit", tx_data);
        end else begin
          exp_b = tx_exp.pop_front();
          if (tx_data !== exp_b) begin
            n_fail = n_fail + 1;
            $display("FAIL tx_byte: got %h expected %h (cycle %0d)", tx_data, exp_b, cycle);
          end
        end
        n_checks = n_checks + 1;
        if (tx_busy !== 1'b0) begin
          n_fail = n_fail + 1;
          $display("FAIL tx_while_busy: busy=%b at start pulse, required 0", tx_busy);
        end
        n_checks = n_checks + 1;
        if (prev_start) begin
          n_fail = n_fail + 1;
          $display("FAIL tx_consecutive: start on two cycles in a row, required gap");
        end
      end
      if (imem_we === 1'b1) begin
        we_count = we_count + 1;
        n_checks = n_checks + 1;
        if (we_exp.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL imem_unexpected: got addr %h data %h, expected no write",
                   imem_addr, imem_data);
        end else begin
          exp_w = we_exp.pop_front();
          if ({imem_addr, imem_data} !== exp_w) begin
            n_fail = n_fail + 1;
            $display("FAIL imem_write: got %h/%h expected %h/%h", imem_addr, imem_data,
                     exp_w[AW+31:32], exp_w[31:0]);
          end
        end
        n_checks = n_checks + 1;
        if (prev_we) begin
          n_fail = n_fail + 1;
          $display("FAIL imem_we_width: we high two cycles, required one");
        end
      end
    end
    prev_start = (tx_start === 1'b1);
    prev_we    = (imem_we === 1'b1);
    if (tx_start === 1'b1) begin
      tx_busy   = 1'b1;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    halt = halt_arm && (stall_low_cnt >= halt_after);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_dump(input logic [31:0] pc_v);
    for (int b = 3; b >= 0; b--) tx_exp.push_back(pc_v[b*8 +: 8]);
    for (int r = 0; r < int'(NREG); r++) begin
      for (int b = 3; b >= 0; b--) tx_exp.push_back(regs[r][b*8 +: 8]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks = n_checks + 7;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b expected 1", stall); end
    if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", imem_we); end
    if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    if (imem_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", imem_data); end
    if (dbg_addr !== 5'd0) begin n_fail++; $display("FAIL reset_dbg_addr: got %h expected 0", dbg_addr); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignored_bytes();
    int tx0;
    tx0 = tx_count;
    send_byte(8'h00);
    send_byte(8'h58);
    repeat (20) @(negedge clk);
    n_checks = n_checks + 2;
    if (tx_count !== tx0) begin n_fail++; $display("FAIL ignored_tx: got %0d bytes expected 0", tx_count - tx0); end
    if (stall !== 1'b1) begin n_fail++; $display("FAIL ignored_stall: got %b expected 1", stall); end
  endtask

  task automatic test_load();
    logic [7:0] seq [10];
    int base;
    seq = '{8'h4C, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h3F};
    base = stall_low_cnt;
    we_exp.push_back({8'd0, 32'h2001_0005});
    we_exp.push_back({8'd1, 32'h0000_003F});
    tx_exp.push_back(8'h06);
    for (int i = 0; i < 10; i++) send_byte(seq[i]);
    for (int i = 0; i < 200 && (tx_exp.size() != 0 || we_exp.size() != 0); i++) @(negedge clk);
    n_checks = n_checks + 4;
    if (we_exp.size() != 0) begin n_fail++; $display("FAIL load_writes: %0d writes missing, expected 0", we_exp.size()); end
    if (tx_exp.size() != 0) begin n_fail++; $display("FAIL load_ack: %0d bytes missing, expected 0", tx_exp.size()); end
    if (stall_low_cnt - base != 0) begin n_fail++; $display("FAIL load_stall: low %0d cycles expected 0", stall_low_cnt - base); end
    if (stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_end: got %b expected 1", stall); end
  endtask

  task automatic test_step();
    int base;
    base = stall_low_cnt;
    pc = 32'h0000_0004;
    push_dump(pc);
    send_byte(8'h53);
    repeat (40) @(negedge clk);
    send_byte(8'h4C);  // must be dropped while dumping
    for (int i = 0; i < 3000 && tx_exp.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_checks = n_checks + 3;
    if (tx_exp.size() != 0) begin n_fail++; $display("FAIL step_dump: %0d bytes missing, expected 0", tx_exp.size()); end
    if (stall_low_cnt - base != 1) begin n_fail++; $display("FAIL step_stall_low: got %0d cycles expected 1", stall_low_cnt - base); end
    if (stall !== 1'b1) begin n_fail++; $display("FAIL step_stall_end: got %b expected 1", stall); end
  endtask

  task automatic test_run();
    int base;
    base = stall_low_cnt;
    pc = 32'h0000_0040;
    for (int r = 0; r < int'(NREG); r++) regs[r] = 32'hA500_0000 | (r * 32'h0001_0203);
    halt_after = base + 10;
    halt_arm = 1'b1;
    push_dump(pc);
    send_byte(8'h43);
    for (int i = 0; i < 3000 && tx_exp.size() != 0; i++) @(negedge clk);
    halt_arm = 1'b0;
    repeat (5) @(negedge clk);
    n_checks = n_checks + 3;
    if (tx_exp.size() != 0) begin n_fail++; $display("FAIL run_dump: %0d bytes missing, expected 0", tx_exp.size()); end
    if (stall_low_cnt - base != 10) begin n_fail++; $display("FAIL run_stall_low: got %0d cycles expected 10", stall_low_cnt - base); end
    if (stall !== 1'b1) begin n_fail++; $display("FAIL run_stall_end: got %b expected 1", stall); end
  endtask

  task automatic test_backpressure();
    int tx0;
    tx0 = tx_count;
    busy_len = 50;
    pc = 32'h1234_5678;
    for (int r = 0; r < int'(NREG); r++) regs[r] = ~(32'h0101_0101 * r);
    push_dump(pc);
    send_byte(8'h44);
    for (int i = 0; i < 9000 && tx_exp.size() != 0; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    busy_len = 2;
    n_checks = n_checks + 2;
    if (tx_exp.size() != 0) begin n_fail++; $display("FAIL bp_dump: %0d bytes missing, expected 0", tx_exp.size()); end
    if (tx_count - tx0 != 132) begin n_fail++; $display("FAIL bp_count: got %0d bytes expected 132", tx_count - tx0); end
  endtask

  task automatic test_reset_mid_load();
    int we0;
    we0 = we_count;
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks = n_checks + 4;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL midrst_stall: got %b expected 1", stall); end
    if (imem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b expected 0", imem_we); end
    if (imem_addr !== '0) begin n_fail++; $display("FAIL midrst_addr: got %h expected 0", imem_addr); end
    if (imem_data !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", imem_data); end
    rst = 1'b1;
    pc = 32'h0000_0008;
    push_dump(pc);
    send_byte(8'h44);
    for (int i = 0; i < 3000 && tx_exp.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_checks = n_checks + 2;
    if (tx_exp.size() != 0) begin n_fail++; $display("FAIL midrst_dump: %0d bytes missing, expected 0", tx_exp.size()); end
    if (we_count != we0) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes expected 0", we_count - we0); end
  endtask

`ifdef DEBUG_TIMEOUT_EN
  task automatic test_timeout();
    int we0;
    int c0;
    we0 = we_count;
    tx_exp.push_back(8'h15);
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'hAA);
    c0 = cycle;
    for (int i = 0; i < 400 && tx_exp.size() != 0; i++) @(negedge clk);
    n_checks = n_checks + 3;
    if (tx_exp.size() != 0) begin n_fail++; $display("FAIL tmo_nak: NAK missing, expected 0x15"); end
    if (last_tx_cycle - c0 < 95 || last_tx_cycle - c0 > 110) begin
      n_fail++;
      $display("FAIL tmo_latency: got %0d cycles expected about 100", last_tx_cycle - c0);
    end
    if (we_count != we0) begin n_fail++; $display("FAIL tmo_no_write: got %0d writes expected 0", we_count - we0); end
    repeat (5) @(negedge clk);
    push_dump(pc);
    send_byte(8'h44);
    for (int i = 0; i < 3000 && tx_exp.size() != 0; i++) @(negedge clk);
    n_checks = n_checks + 1;
    if (tx_exp.size() != 0) begin n_fail++; $display("FAIL tmo_dump_after: %0d bytes missing, expected 0", tx_exp.size()); end
  endtask
`endif

  initial begin
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    pc       = 32'h0;
    for (int r = 0; r < int'(NREG); r++) regs[r] = r;
    test_reset();
    test_ignored_bytes();
    test_load();
    test_step();
    for (int r = 0; r < int'(NREG); r++) regs[r] = r;
    test_run();
    test_backpressure();
    test_reset_mid_load();
`ifdef DEBUG_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
